dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the MEM stage and a multi-cycle main data memory.
- The MEM stage issues word reads/writes. The controller answers hits in the same cycle.
- On a miss it raises stall. The top level uses stall to freeze all pipeline registers until the access completes.
- The memory side uses a hold-until-ready line-transfer handshake.

Parameters:
- LINES, 8, number of cache lines; power of 2, 2..64.
- WORDS_PER_LINE, 4, 16-bit words per line; fixed at 4 in this revision (line = 64 bits).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cpu_re  in  1  load request (MemRead from MEM stage)
- cpu_we  in  1  store request (MemWrite from MEM stage)
- cpu_addr  in  16  word address
- cpu_wdata  in  16  store data
- cpu_rdata  out  16  load data; valid when cpu_re=1 and stall=0
- stall  out  1  freeze pipeline; current access not complete
- mem_re  out  1  line fill request
- mem_we  out  1  line writeback request
- mem_addr  out  14  line address (word address [15:2])
- mem_wline  out  64  victim line; word 0 in [15:0]
- mem_rline  in  64  fill line; valid when mem_rdy=1 during a fill
- mem_rdy  in  1  one-cycle pulse: current mem request complete

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On reset, all valid and dirty bits clear and the FSM goes to IDLE.
  - All outputs are 0 after the reset edge.
  - Data and tag arrays are not cleared.
- Address split (LINES=8):
  - offset = addr[1:0]
  - index = addr[1+log2(LINES):2]
  - tag = remaining upper bits
- hit = valid[index] and tag match.
- Access rules:
  - Access active = cpu_re or cpu_we.
  - If both are asserted, treat as a store; cpu_rdata returns the pre-write word.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE:
  - Hit read: cpu_rdata is the combinational word select; stall=0.
  - Hit write: at the clk edge, the word updates and dirty[index] is set; stall=0.
  - Miss with victim clean or invalid: stall=1 combinationally; go to FILL next cycle.
  - Miss with victim valid and dirty: stall=1; go to WRITEBACK.
- WRITEBACK:
  - stall=1, mem_we=1.
  - mem_addr = {victim tag, index}; mem_wline = victim line. Both held stable.
  - On mem_rdy, go to FILL.
- FILL:
  - stall=1, mem_re=1, mem_addr = cpu_addr[15:2], held stable.
  - On mem_rdy: write mem_rline into the data array, write the tag, set valid, clear dirty, go to IDLE.
- Replay: the next cycle in IDLE re-evaluates and now hits. Stall drops that cycle, and a store merges then, setting dirty.
- Miss latency (mem latency L cycles from request to mem_rdy):
  - Clean miss: stall high for L+1 cycles.
  - Dirty miss: stall high for 2L+1 cycles.
- mem_re and mem_we are never high together.
- The CPU holds cpu_* stable while stall=1. The controller does not re-sample them mid-miss.
- Ignored inputs:
  - mem_rdy in IDLE is ignored.
  - Access with cpu_re=cpu_we=0 never stalls.
- Reset mid-miss: the request is abandoned and mem_re/mem_we drop after the edge. The memory model must drop an outstanding request when its request line deasserts.

Optional Feature:
- DCACHE_STATS_EN: adds outputs hit_cnt[15:0] and miss_cnt[15:0].
  - Counters are saturating at 16'hFFFF and cleared by rst.
  - hit_cnt increments per completed access that hit on first evaluation.
  - miss_cnt increments once per miss at IDLE→WRITEBACK/FILL; replay cycles are not counted.
- Without the macro, the ports and counters are absent.

Decomposition:
- Shared package wisc_cache_pkg:
  - dc_state_t enum (IDLE, WRITEBACK, FILL)
  - typedef line_t as logic [63:0]
  - constants WORD_W=16, LINE_ADDR_W=14
  - function word_sel(line_t, offset)
- Sub-module dcache_array:
  - tag/valid/dirty/data storage
  - one combinational read port, one synchronous write port with full-line write and single-word write plus dirty set
  - synchronous clear of valid/dirty on rst
- dcache_ctrl holds the FSM, hit logic and memory handshake.

Test Plan:
- Cold read 0x0010, memory returns line {0x4444,0x3333,0x2222,0x1111} with L=4 → stall high 5 cycles, mem_re with mem_addr=0x0004, then cpu_rdata=0x1111 with stall=0; read 0x0012 → 0x3333 with no stall.
- Store 0xBEEF to 0x0011 after the fill above → no stall, dirty set; read 0x0011 → 0xBEEF.
- Read 0x0110 (same index 4, different tag) while dirty → mem_we with mem_addr=0x0004 and mem_wline word1=0xBEEF, then mem_re with mem_addr=0x0044; stall high 9 cycles.
- Both cpu_re and cpu_we high on a hit at 0x0012 with wdata 0x5555 → cpu_rdata=0x3333 that cycle; next read returns 0x5555.
- rst asserted during FILL (cycle 2 of L) → next cycle mem_re=0, stall=0, all lines invalid; re-read of 0x0010 misses again.
- With DCACHE_STATS_EN, sequence miss, hit, hit, miss → hit_cnt=2, miss_cnt=2.

Source files
------------

// File: rtl/dcache_ctrl_pkg.sv
// Shared types, widths and helpers for the data cache controller slice.
// Package name is wisc_cache_pkg so it can be shared with other cache blocks.
package wisc_cache_pkg;

  localparam int WORD_W         = 16;
  localparam int LINE_ADDR_W    = 14;
  localparam int WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } dc_state_t;

  typedef logic [63:0] line_t;

  // Pick one 16-bit word out of a line; word 0 sits in bits [15:0].
  function automatic logic [WORD_W-1:0] word_sel(input line_t line, input logic [1:0] offset);
    return line[offset*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Line-transfer bus between the cache controller (master) and main memory (slave).
// Requests are held until mem_rdy pulses for one cycle.
interface dcache_mem_if;
  import wisc_cache_pkg::*;

  logic                   mem_re;
  logic                   mem_we;
  logic [LINE_ADDR_W-1:0] mem_addr;
  line_t                  mem_wline;
  line_t                  mem_rline;
  logic                   mem_rdy;

  modport master (
    output mem_re, mem_we, mem_addr, mem_wline,
    input  mem_rline, mem_rdy
  );

  modport slave (
    input  mem_re, mem_we, mem_addr, mem_wline,
    output mem_rline, mem_rdy
  );

endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the direct-mapped data cache.
// One combinational read port; one synchronous write port that either writes a
// whole line (fill: sets valid, clears dirty) or a single word (store: sets dirty).
module dcache_array
  import wisc_cache_pkg::*;
#(
  parameter int LINES = 8,
  localparam int IDX_W = $clog2(LINES),
  localparam int TAG_W = 16 - 2 - IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  index,
  // full-line write
  input  logic              line_we,
  input  logic [TAG_W-1:0]  line_tag,
  input  line_t             line_data,
  // single-word write
  input  logic              word_we,
  input  logic [1:0]        word_off,
  input  logic [WORD_W-1:0] word_data,
  // read port
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output line_t             rd_line
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  line_t            data_q [LINES];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_line  = data_q[index];

  // Status bits: cleared on reset, set/cleared by fills and stores.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and data storage; written by fills (whole line) and stores (one word).
  // NOTE: the arrays are deliberately not reset; valid bits gate their use, and a
  // reset-free array maps onto RAM instead of a flop bank with a clear tree.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[index]  <= line_tag;
      data_q[index] <= line_data;
    end else if (word_we) begin
      data_q[index][word_off*WORD_W +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete in the access cycle; misses raise stall while a dirty victim is
// written back (WRITEBACK) and the missing line is fetched (FILL), then the
// access replays in IDLE and hits.
// Optional build macro DCACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module dcache_ctrl
  import wisc_cache_pkg::*;
#(
  parameter int LINES          = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              stall,
`ifdef DCACHE_STATS_EN
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
`endif
  dcache_mem_if.master      mem
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 16 - 2 - IDX_W;

  dc_state_t state;

  logic [IDX_W-1:0] cpu_idx;
  logic [TAG_W-1:0] cpu_tag;
  logic [1:0]       cpu_off;
  logic             active;
  logic             hit;

  logic             rd_valid;
  logic             rd_dirty;
  logic [TAG_W-1:0] rd_tag;
  line_t            rd_line;
  logic             line_we;
  logic             word_we;

  assign cpu_off = cpu_addr[1:0];
  assign cpu_idx = cpu_addr[IDX_W+1:2];
  assign cpu_tag = cpu_addr[15:IDX_W+2];
  assign active  = cpu_re | cpu_we;

  // A fill completes on mem_rdy in FILL; a store merges only on an IDLE hit.
  assign line_we = (state == FILL) && mem.mem_rdy && !rst;
  assign word_we = (state == IDLE) && cpu_we && hit && !rst;

  dcache_array #(.LINES(LINES)) u_array (
    .clk       (clk),
    .rst       (rst),
    .index     (cpu_idx),
    .line_we   (line_we),
    .line_tag  (cpu_tag),
    .line_data (mem.mem_rline),
    .word_we   (word_we),
    .word_off  (cpu_off),
    .word_data (cpu_wdata),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line)
  );

  // Hit detection, load data and stall, all combinational off the array read.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    hit       = 1'b0;
    cpu_rdata = '0;
    stall     = 1'b0;
    hit       = rd_valid && (rd_tag == cpu_tag);
    if ((state == IDLE) && cpu_re && hit) begin
      cpu_rdata = word_sel(rd_line, cpu_off);
    end
    stall = (state != IDLE) || (active && !hit);
  end

  // Miss FSM with registered memory-side outputs held stable for each request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mem.mem_re    <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wline <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (active && !hit) begin
            if (rd_valid && rd_dirty) begin
              state         <= WRITEBACK;
              mem.mem_we    <= 1'b1;
              mem.mem_addr  <= {rd_tag, cpu_idx};
              mem.mem_wline <= rd_line;
            end else begin
              state        <= FILL;
              mem.mem_re   <= 1'b1;
              mem.mem_addr <= cpu_addr[15:2];
            end
          end
        end
        WRITEBACK: begin
          if (mem.mem_rdy) begin
            state         <= FILL;
            mem.mem_we    <= 1'b0;
            mem.mem_re    <= 1'b1;
            mem.mem_addr  <= cpu_addr[15:2];
            mem.mem_wline <= '0;
          end
        end
        FILL: begin
          if (mem.mem_rdy) begin
            state        <= IDLE;
            mem.mem_re   <= 1'b0;
            mem.mem_addr <= '0;
          end
        end
        default: begin
          state         <= IDLE;
          mem.mem_re    <= 1'b0;
          mem.mem_we    <= 1'b0;
          mem.mem_addr  <= '0;
          mem.mem_wline <= '0;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic replay_q;

  // Marks the IDLE cycle right after a fill so the replayed hit is not counted.
  always_ff @(posedge clk) begin
    if (rst) replay_q <= 1'b0;
    else     replay_q <= (state == FILL) && mem.mem_rdy;
  end

  // Saturating counters: first-evaluation hits and IDLE-detected misses.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if ((state == IDLE) && active) begin
      if (hit && !replay_q && (hit_cnt != 16'hFFFF)) hit_cnt <= hit_cnt + 16'd1;
      if (!hit && (miss_cnt != 16'hFFFF))            miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule
